// File: rtl/bram_ctrl_pkg.sv
// Shared definitions for the BRAM stream controller: FSM state type and default geometry.
package bram_ctrl_pkg;

  localparam int DEF_DWIDTH   = 32;
  localparam int DEF_AWIDTH   = 12;
  localparam int DEF_MEM_SIZE = 3840;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    DONE
  } state_t;

endpackage

// File: rtl/bram_stream_ctrl_if.sv
// Stream and BRAM port bundle of bram_stream_ctrl; master = controller side,
// slave = the environment (stream source/sink plus the dual-port BRAM).
interface bram_stream_ctrl_if #(
  parameter int DWIDTH = bram_ctrl_pkg::DEF_DWIDTH,
  parameter int AWIDTH = bram_ctrl_pkg::DEF_AWIDTH
);

  logic              s_valid_i;
  logic              s_ready_o;
  logic [DWIDTH-1:0] s_data_i;
  logic              m_valid_o;
  logic              m_ready_i;
  logic [DWIDTH-1:0] m_data_o;
  logic [AWIDTH-1:0] addr0_o;
  logic              ce0_o;
  logic              we0_o;
  logic [DWIDTH-1:0] d0_o;
  logic [AWIDTH-1:0] addr1_o;
  logic              ce1_o;
  logic              we1_o;
  logic [DWIDTH-1:0] q1_i;

  modport master (
    input  s_valid_i, s_data_i, m_ready_i, q1_i,
    output s_ready_o, m_valid_o, m_data_o,
    output addr0_o, ce0_o, we0_o, d0_o,
    output addr1_o, ce1_o, we1_o
  );

  modport slave (
    output s_valid_i, s_data_i, m_ready_i, q1_i,
    input  s_ready_o, m_valid_o, m_data_o,
    input  addr0_o, ce0_o, we0_o, d0_o,
    input  addr1_o, ce1_o, we1_o
  );

endinterface

// File: rtl/stream_fifo2.sv
// Two-entry output FIFO; a push into a full FIFO is accepted only when the head
// is popped in the same cycle.
module stream_fifo2
  import bram_ctrl_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic [DWIDTH-1:0] data_i,
  input  logic              pop_i,
  output logic              valid_o,
  output logic [DWIDTH-1:0] data_o,
  output logic [1:0]        count_o
);

  logic [DWIDTH-1:0] mem_q [2];
  logic [DWIDTH-1:0] mem_d [2];
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              do_push, do_pop;

  always_comb begin
    do_pop   = pop_i && (count_q != 2'd0);
    do_push  = push_i && ((count_q != 2'd2) || do_pop);
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign valid_o = (count_q != 2'd0);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/bram_stream_ctrl.sv
// Streams num words into BRAM port 0, then replays them from port 1 through a 2-entry FIFO.
// Optional write/read checksum compare is built when BRAM_STREAM_CTRL_CHECKSUM_EN is defined.
module bram_stream_ctrl
  import bram_ctrl_pkg::*;
#(
  parameter int DWIDTH   = DEF_DWIDTH,
  parameter int AWIDTH   = DEF_AWIDTH,
  parameter int MEM_SIZE = DEF_MEM_SIZE
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_i,
  input  logic [AWIDTH-1:0]  num_i,
  bram_stream_ctrl_if.master bus,
  output logic               busy_o,
  output logic               done_o,
  output logic               sum_err_o
);

  // One extra bit so a count can reach MEM_SIZE even when it equals 2**AWIDTH.
  localparam int            CW        = AWIDTH + 1;
  localparam logic [CW-1:0] MEM_WORDS = CW'(MEM_SIZE);
  localparam logic [CW-1:0] ONE       = CW'(1);

  state_t            state_q, state_d;
  logic [CW-1:0]     num_q, num_d;
  logic [CW-1:0]     wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]     rd_cnt_q, rd_cnt_d;
  logic [CW-1:0]     pop_cnt_q, pop_cnt_d;
  logic              inflight_q, inflight_d;
  logic [CW-1:0]     num_clamped;
  logic              wr_fire, rd_issue, pop;
  logic [2:0]        pending;
  logic              fifo_valid;
  logic [DWIDTH-1:0] fifo_data;
  logic [1:0]        fifo_count;

  // A read is only issued when its data is guaranteed a FIFO slot one cycle later.
  always_comb begin
    num_clamped = ({1'b0, num_i} > MEM_WORDS) ? MEM_WORDS : {1'b0, num_i};
    wr_fire     = (state_q == WRITE) && bus.s_valid_i;
    pop         = (state_q == READ) && fifo_valid && bus.m_ready_i;
    pending     = {1'b0, fifo_count} + {2'b00, inflight_q};
    rd_issue    = (state_q == READ) && (rd_cnt_q < num_q) &&
                  (pending <= (3'd1 + {2'b00, pop}));

    state_d    = state_q;
    num_d      = num_q;
    wr_cnt_d   = wr_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    pop_cnt_d  = pop_cnt_q;
    inflight_d = rd_issue;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          num_d     = num_clamped;
          wr_cnt_d  = '0;
          rd_cnt_d  = '0;
          pop_cnt_d = '0;
          state_d   = (num_clamped == '0) ? DONE : WRITE;
        end
      end
      WRITE: begin
        if (wr_fire) begin
          wr_cnt_d = wr_cnt_q + ONE;
          if (wr_cnt_d == num_q) begin
            state_d = READ;
          end
        end
      end
      READ: begin
        if (rd_issue) begin
          rd_cnt_d = rd_cnt_q + ONE;
        end
        if (pop) begin
          pop_cnt_d = pop_cnt_q + ONE;
          if (pop_cnt_d == num_q) begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      num_q      <= '0;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      pop_cnt_q  <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      pop_cnt_q  <= pop_cnt_d;
      inflight_q <= inflight_d;
    end
  end

  stream_fifo2 #(
    .DWIDTH (DWIDTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (inflight_q),
    .data_i  (bus.q1_i),
    .pop_i   (pop),
    .valid_o (fifo_valid),
    .data_o  (fifo_data),
    .count_o (fifo_count)
  );

  assign bus.s_ready_o = (state_q == WRITE);
  assign bus.ce0_o     = wr_fire;
  assign bus.we0_o     = wr_fire;
  assign bus.addr0_o   = wr_fire ? wr_cnt_q[AWIDTH-1:0] : '0;
  assign bus.d0_o      = wr_fire ? bus.s_data_i : '0;
  assign bus.ce1_o     = rd_issue;
  assign bus.we1_o     = 1'b0;
  assign bus.addr1_o   = rd_issue ? rd_cnt_q[AWIDTH-1:0] : '0;
  assign bus.m_valid_o = (state_q == READ) && fifo_valid;
  assign bus.m_data_o  = bus.m_valid_o ? fifo_data : '0;
  assign busy_o        = (state_q != IDLE);
  assign done_o        = (state_q == DONE);

`ifdef BRAM_STREAM_CTRL_CHECKSUM_EN
  logic [DWIDTH-1:0] wsum_q, wsum_d;
  logic [DWIDTH-1:0] rsum_q, rsum_d;
  logic              sum_err_q, sum_err_d;

  // Sums restart on every accepted start; the verdict is latched in DONE and held until the next start.
  always_comb begin
    wsum_d    = wsum_q;
    rsum_d    = rsum_q;
    sum_err_d = sum_err_q;
    if ((state_q == IDLE) && start_i) begin
      wsum_d    = '0;
      rsum_d    = '0;
      sum_err_d = 1'b0;
    end
    if (wr_fire) begin
      wsum_d = wsum_q + bus.s_data_i;
    end
    if (pop) begin
      rsum_d = rsum_q + fifo_data;
    end
    if (state_q == DONE) begin
      sum_err_d = (wsum_q != rsum_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wsum_q    <= '0;
      rsum_q    <= '0;
      sum_err_q <= 1'b0;
    end else begin
      wsum_q    <= wsum_d;
      rsum_q    <= rsum_d;
      sum_err_q <= sum_err_d;
    end
  end

  assign sum_err_o = sum_err_q;
`else
  assign sum_err_o = 1'b0;
`endif

endmodule

// File: doc/bram_stream_ctrl.md
BRAM_STREAM_CTRL -- requirements
Module: bram_stream_ctrl

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, meaning data word width.
REQ-002 SHALL have parameter AWIDTH, default 12, meaning BRAM address width.
REQ-003 SHALL have parameter MEM_SIZE, default 3840, meaning number of usable BRAM words.
REQ-004 SHALL have the following ports, one per line:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start_i  in  1  begin a transfer; sampled only in IDLE.
- num_i  in  AWIDTH  transfer length in words; latched on start.
- s_valid_i, s_ready_o, s_data_i[DWIDTH]  in/out/in  input stream.
- m_valid_o, m_ready_i, m_data_o[DWIDTH]  out/in/out  output stream.
- addr0_o[AWIDTH], ce0_o, we0_o, d0_o[DWIDTH]  out  BRAM port 0, write only.
- addr1_o[AWIDTH], ce1_o, we1_o  out  BRAM port 1, read only.
- q1_i[DWIDTH]  in  BRAM port 1 read data.
- busy_o  out  1  not in IDLE.
- done_o  out  1  one-cycle pulse when a transfer completes.
- sum_err_o  out  1  checksum mismatch, sticky until next start.

Function
REQ-005 SHALL implement FSM states IDLE, WRITE, READ, DONE; DONE lasts one cycle, asserts done_o, then returns to IDLE.
REQ-006 SHALL transition from IDLE to WRITE when start_i=1; num_i=0 SHALL go directly to DONE; num_i>MEM_SIZE SHALL be clamped to MEM_SIZE.
REQ-007 In WRITE, s_ready_o SHALL be 1; each s_valid_i&s_ready_o beat SHALL drive ce0_o=1, we0_o=1, addr0_o=write count, d0_o=s_data_i combinationally in the same cycle.
REQ-008 WRITE SHALL end after num words are written; the next cycle SHALL be READ, with the write counter not exceeding num.
REQ-009 In READ, reads SHALL be issued on port 1 with ce1_o=1, we1_o=0, and ascending addr1_o from 0; we1_o SHALL always be 0.
REQ-010 SHALL model one-cycle BRAM read latency: q1_i is valid the cycle after a read is issued, and SHALL be captured into a 2-entry output FIFO.
REQ-011 SHALL issue a read only if FIFO occupancy plus in-flight reads minus the pop this cycle is 1 or less, so the FIFO never overflows under arbitrary m_ready_i.
REQ-012 m_valid_o SHALL equal FIFO non-empty, and m_data_o SHALL be the FIFO head; both SHALL be stable while m_valid_o=1 and m_ready_i=0.
REQ-013 READ SHALL end when num words have been popped, then go to DONE.
REQ-014 ce0_o, ce1_o, s_ready_o and m_valid_o SHALL be 0 outside their respective states.
REQ-015 start_i SHALL be ignored while busy_o=1.

Reset
REQ-016 On reset, the FSM SHALL go to IDLE; counters and FIFO SHALL clear; all outputs SHALL be 0, including sum_err_o and done_o.
REQ-017 Reset asserted mid-transfer SHALL abort immediately with no further BRAM accesses; partially written BRAM contents are don't-care.

Configuration
REQ-018 With macro BRAM_STREAM_CTRL_CHECKSUM_EN defined, the block SHALL accumulate a DWIDTH-bit modulo sum of written words and of popped words, and in DONE SHALL set sum_err_o if the two differ.
REQ-019 Without BRAM_STREAM_CTRL_CHECKSUM_EN, no accumulators SHALL be built and sum_err_o SHALL be tied to 0.

Structure
REQ-020 A shared package bram_ctrl_pkg SHALL hold the FSM state typedef and default DWIDTH/AWIDTH/MEM_SIZE constants.
REQ-021 The 2-entry output FIFO SHALL be a sub-module named stream_fifo2.

Verification
REQ-022 Single word: num=1, write 0xDEADBEEF -> one port-0 write to addr 0, then m_data_o=0xDEADBEEF, done_o pulses once.
REQ-023 Streaming: num=16, data 0..15, m_ready_i=1 -> output 0..15 in order, a back-to-back output rate of 1 word/cycle after the first, no gaps.
REQ-024 Backpressure: num=8, m_ready_i toggled pseudo-randomly -> no loss or duplication, m_data_o stable while stalled, FIFO never more than 2 entries.
REQ-025 Boundaries: num=0 -> done_o the cycle after start with no BRAM access; num=4095 -> exactly 3840 writes, last addr0_o=3839.
REQ-026 Reset mid-READ after 5 of 10 words -> all outputs 0 next cycle; a new start with num=3 completes correctly.
REQ-027 Checksum with macro defined: corrupt q1_i on word 2 -> sum_err_o=1 after DONE; clean run -> sum_err_o=0.
